rs_alu_scheduler: RTL and testbench

RS_ALU_SCHEDULER -- requirements
Module: rs_alu_scheduler

---
 rtl/rs_alu_scheduler.sv | 165 ++++++++++++++++
 tb/tb_rs_alu_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_scheduler.sv
// Reservation station for the ALU. It holds dispatched instructions until both operands are
// ready, snoops two result buses, and issues one instruction per cycle, lowest index first.
module rs_alu_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             rob_clear_in,
    input  logic             dispatch_signal_in,
    input  logic [OP_W-1:0]  dispatch_op_in,
    input  logic [31:0]      dispatch_imm_in,
    input  logic [31:0]      dispatch_pc_in,
    input  logic [31:0]      dispatch_rs1val_in,
    input  logic [31:0]      dispatch_rs2val_in,
    input  logic             dispatch_rs1ready_in,
    input  logic             dispatch_rs2ready_in,
    input  logic [TAG_W-1:0] dispatch_rs1tag_in,
    input  logic [TAG_W-1:0] dispatch_rs2tag_in,
    input  logic [TAG_W-1:0] dispatch_dest_in,
    input  logic             alu_broadcast_in,
    input  logic [TAG_W-1:0] alu_tag_in,
    input  logic [31:0]      alu_result_in,
    input  logic             lsb_broadcast_in,
    input  logic [TAG_W-1:0] lsb_tag_in,
    input  logic [31:0]      lsb_result_in,
    output logic             full_out,
    output logic             alu_calculate_signal_out,
    output logic [OP_W-1:0]  alu_op_out,
    output logic [31:0]      alu_imm_out,
    output logic [31:0]      alu_pc_out,
    output logic [31:0]      alu_rs1val_out,
    output logic [31:0]      alu_rs2val_out,
    output logic [TAG_W-1:0] alu_dest_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } wake_t;

    logic [RS_SIZE-1:0] busy, rdy1, rdy2;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [31:0]        val1_q [RS_SIZE];
    logic [31:0]        val2_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];

    logic [IDX_W-1:0]   free_idx, issue_idx;
    logic               issue_found;
    logic               do_dispatch;
    wake_t              w1 [RS_SIZE];
    wake_t              w2 [RS_SIZE];
    wake_t              d1, d2;

    // ALU bus wins when both buses carry the same tag.
    function automatic wake_t snoop(input logic [TAG_W-1:0] tag);
        wake_t w;
        w.hit = 1'b0;
        w.val = lsb_result_in;
        if (alu_broadcast_in && alu_tag_in == tag) begin
            w.hit = 1'b1;
            w.val = alu_result_in;
        end else if (lsb_broadcast_in && lsb_tag_in == tag) begin
            w.hit = 1'b1;
        end
        return w;
    endfunction

    assign full_out    = &busy;
    assign do_dispatch = dispatch_signal_in && !full_out;

    // NOTE: every comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        free_idx    = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        // Scan high to low so the lowest matching index is the last assignment.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (busy[i] && rdy1[i] && rdy2[i]) begin
                issue_idx   = IDX_W'(i);
                issue_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w1[i] = snoop(tag1_q[i]);
            w2[i] = snoop(tag2_q[i]);
        end
        d1 = snoop(dispatch_rs1tag_in);
        d2 = snoop(dispatch_rs2tag_in);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy                     <= '0;
            rdy1                     <= '0;
            rdy2                     <= '0;
            alu_calculate_signal_out <= 1'b0;
            alu_op_out               <= '0;
            alu_imm_out              <= '0;
            alu_pc_out               <= '0;
            alu_rs1val_out           <= '0;
            alu_rs2val_out           <= '0;
            alu_dest_out             <= '0;
        end else if (rob_clear_in) begin
            busy                     <= '0;
            alu_calculate_signal_out <= 1'b0;
        end else if (rdy_in) begin
            alu_calculate_signal_out <= issue_found;
            if (issue_found) begin
                alu_op_out        <= op_q[issue_idx];
                alu_imm_out       <= imm_q[issue_idx];
                alu_pc_out        <= pc_q[issue_idx];
                alu_rs1val_out    <= val1_q[issue_idx];
                alu_rs2val_out    <= val2_q[issue_idx];
                alu_dest_out      <= dest_q[issue_idx];
                busy[issue_idx]   <= 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rdy1[i] && w1[i].hit) rdy1[i] <= 1'b1;
                if (busy[i] && !rdy2[i] && w2[i].hit) rdy2[i] <= 1'b1;
            end
            if (do_dispatch) begin
                busy[free_idx] <= 1'b1;
                rdy1[free_idx] <= dispatch_rs1ready_in || d1.hit;
                rdy2[free_idx] <= dispatch_rs2ready_in || d2.hit;
            end
        end else begin
            alu_calculate_signal_out <= 1'b0;
        end
    end

    // NOTE: entry payload storage has no reset; busy/ready bits alone decide whether it is meaningful.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rdy1[i] && w1[i].hit) val1_q[i] <= w1[i].val;
                if (busy[i] && !rdy2[i] && w2[i].hit) val2_q[i] <= w2[i].val;
            end
            if (do_dispatch) begin
                op_q[free_idx]   <= dispatch_op_in;
                imm_q[free_idx]  <= dispatch_imm_in;
                pc_q[free_idx]   <= dispatch_pc_in;
                dest_q[free_idx] <= dispatch_dest_in;
                tag1_q[free_idx] <= dispatch_rs1tag_in;
                tag2_q[free_idx] <= dispatch_rs2tag_in;
                val1_q[free_idx] <= dispatch_rs1ready_in ? dispatch_rs1val_in : d1.val;
                val2_q[free_idx] <= dispatch_rs2ready_in ? dispatch_rs2val_in : d2.val;
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Bench for rs_alu_scheduler: directed scenarios followed by random traffic, every cycle
// compared against a behavioural station model.
module tb_rs_alu_scheduler;

    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 6;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             rdy_in, rob_clear_in, dispatch_signal_in;
    logic [OP_W-1:0]  dispatch_op_in;
    logic [31:0]      dispatch_imm_in, dispatch_pc_in, dispatch_rs1val_in, dispatch_rs2val_in;
    logic             dispatch_rs1ready_in, dispatch_rs2ready_in;
    logic [TAG_W-1:0] dispatch_rs1tag_in, dispatch_rs2tag_in, dispatch_dest_in;
    logic             alu_broadcast_in, lsb_broadcast_in;
    logic [TAG_W-1:0] alu_tag_in, lsb_tag_in;
    logic [31:0]      alu_result_in, lsb_result_in;
    logic             full_out, alu_calculate_signal_out;
    logic [OP_W-1:0]  alu_op_out;
    logic [31:0]      alu_imm_out, alu_pc_out, alu_rs1val_out, alu_rs2val_out;
    logic [TAG_W-1:0] alu_dest_out;

    always #5 clk_in = ~clk_in;

    rs_alu_scheduler #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear_in(rob_clear_in),
        .dispatch_signal_in(dispatch_signal_in), .dispatch_op_in(dispatch_op_in),
        .dispatch_imm_in(dispatch_imm_in), .dispatch_pc_in(dispatch_pc_in),
        .dispatch_rs1val_in(dispatch_rs1val_in), .dispatch_rs2val_in(dispatch_rs2val_in),
        .dispatch_rs1ready_in(dispatch_rs1ready_in), .dispatch_rs2ready_in(dispatch_rs2ready_in),
        .dispatch_rs1tag_in(dispatch_rs1tag_in), .dispatch_rs2tag_in(dispatch_rs2tag_in),
        .dispatch_dest_in(dispatch_dest_in),
        .alu_broadcast_in(alu_broadcast_in), .alu_tag_in(alu_tag_in), .alu_result_in(alu_result_in),
        .lsb_broadcast_in(lsb_broadcast_in), .lsb_tag_in(lsb_tag_in), .lsb_result_in(lsb_result_in),
        .full_out(full_out), .alu_calculate_signal_out(alu_calculate_signal_out),
        .alu_op_out(alu_op_out), .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out),
        .alu_rs1val_out(alu_rs1val_out), .alu_rs2val_out(alu_rs2val_out), .alu_dest_out(alu_dest_out)
    );

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [31:0]      imm, pc;
        logic [TAG_W-1:0] dest;
        logic             r1, r2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0]      v1, v2;
    } ent_t;

    ent_t             m [RS_SIZE];
    logic             e_strobe;
    logic [OP_W-1:0]  e_op;
    logic [31:0]      e_imm, e_pc, e_v1, e_v2;
    logic [TAG_W-1:0] e_dest;
    int               total = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_full();
        for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m[i] = '0;
        e_strobe = 0; e_op = '0; e_imm = '0; e_pc = '0; e_v1 = '0; e_v2 = '0; e_dest = '0;
    endtask

    // Value a waiting operand would pick up from the buses this cycle, ALU bus first.
    task automatic bus_value(input logic [TAG_W-1:0] tag, output logic hit, output logic [31:0] val);
        hit = 1'b0; val = '0;
        if (alu_broadcast_in && alu_tag_in == tag) begin hit = 1'b1; val = alu_result_in; end
        else if (lsb_broadcast_in && lsb_tag_in == tag) begin hit = 1'b1; val = lsb_result_in; end
    endtask

    task automatic model_step();
        ent_t old [RS_SIZE];
        int k;
        logic h;
        logic [31:0] v;
        if (rob_clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            e_strobe = 1'b0;
            return;
        end
        if (!rdy_in) begin
            e_strobe = 1'b0;
            return;
        end
        old = m;
        e_strobe = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!e_strobe && old[i].busy && old[i].r1 && old[i].r2) begin
                e_strobe = 1'b1;
                e_op = old[i].op; e_imm = old[i].imm; e_pc = old[i].pc;
                e_v1 = old[i].v1; e_v2 = old[i].v2; e_dest = old[i].dest;
                m[i].busy = 1'b0;
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (old[i].busy && !old[i].r1) begin
                bus_value(old[i].t1, h, v);
                if (h) begin m[i].r1 = 1'b1; m[i].v1 = v; end
            end
            if (old[i].busy && !old[i].r2) begin
                bus_value(old[i].t2, h, v);
                if (h) begin m[i].r2 = 1'b1; m[i].v2 = v; end
            end
        end
        if (dispatch_signal_in) begin
            k = -1;
            for (int i = 0; i < RS_SIZE; i++) if (k < 0 && !old[i].busy) k = i;
            if (k >= 0) begin
                m[k].busy = 1'b1; m[k].op = dispatch_op_in; m[k].imm = dispatch_imm_in;
                m[k].pc = dispatch_pc_in; m[k].dest = dispatch_dest_in;
                m[k].r1 = dispatch_rs1ready_in; m[k].t1 = dispatch_rs1tag_in; m[k].v1 = dispatch_rs1val_in;
                m[k].r2 = dispatch_rs2ready_in; m[k].t2 = dispatch_rs2tag_in; m[k].v2 = dispatch_rs2val_in;
                if (!m[k].r1) begin
                    bus_value(m[k].t1, h, v);
                    if (h) begin m[k].r1 = 1'b1; m[k].v1 = v; end
                end
                if (!m[k].r2) begin
                    bus_value(m[k].t2, h, v);
                    if (h) begin m[k].r2 = 1'b1; m[k].v2 = v; end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("strobe", 32'(alu_calculate_signal_out), 32'(e_strobe));
        check("full",   32'(full_out),   32'(model_full()));
        check("op",     32'(alu_op_out), 32'(e_op));
        check("imm",    alu_imm_out,     e_imm);
        check("pc",     alu_pc_out,      e_pc);
        check("rs1val", alu_rs1val_out,  e_v1);
        check("rs2val", alu_rs2val_out,  e_v2);
        check("dest",   32'(alu_dest_out), 32'(e_dest));
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_clear_in = 1'b0; dispatch_signal_in = 1'b0;
        alu_broadcast_in = 1'b0; lsb_broadcast_in = 1'b0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic r1, input logic [TAG_W-1:0] t1,
                        input logic [31:0] v1, input logic r2, input logic [TAG_W-1:0] t2,
                        input logic [31:0] v2, input logic [TAG_W-1:0] dest);
        dispatch_signal_in = 1'b1; dispatch_op_in = op;
        dispatch_imm_in = 32'h100 + 32'(dest); dispatch_pc_in = 32'h8000 + 32'(op);
        dispatch_rs1ready_in = r1; dispatch_rs1tag_in = t1; dispatch_rs1val_in = v1;
        dispatch_rs2ready_in = r2; dispatch_rs2tag_in = t2; dispatch_rs2val_in = v2;
        dispatch_dest_in = dest;
    endtask

    task automatic alu_bc(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        alu_broadcast_in = 1'b1; alu_tag_in = tag; alu_result_in = val;
    endtask

    task automatic lsb_bc(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        lsb_broadcast_in = 1'b1; lsb_tag_in = tag; lsb_result_in = val;
    endtask

    initial begin
        rst_n_in = 1'b0;
        idle();
        disp('0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        dispatch_signal_in = 1'b0;
        alu_tag_in = '0; alu_result_in = '0; lsb_tag_in = '0; lsb_result_in = '0;
        model_reset();
        #3;
        compare_all();
        #5 rst_n_in = 1'b1;

        // Both operands ready: issue on the very next edge.
        disp(6'h01, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd3);
        cycle();
        check("add_no_strobe_yet", 32'(alu_calculate_signal_out), 32'd0);
        idle(); cycle();
        check("add_strobe", 32'(alu_calculate_signal_out), 32'd1);
        check("add_rs1", alu_rs1val_out, 32'd5);
        check("add_rs2", alu_rs2val_out, 32'd7);
        check("add_dest", 32'(alu_dest_out), 32'd3);
        check("add_full", 32'(full_out), 32'd0);
        cycle();
        check("add_one_shot", 32'(alu_calculate_signal_out), 32'd0);

        // rs1 waits for tag 2, woken by the load-store bus two cycles later.
        disp(6'h02, 1'b0, 4'd2, 32'hdead, 1'b1, 4'd0, 32'd1, 4'd6);
        cycle();
        idle(); cycle();
        lsb_bc(4'd2, 32'h10); cycle();
        check("lsb_wait_strobe", 32'(alu_calculate_signal_out), 32'd0);
        idle(); cycle();
        check("lsb_issue_strobe", 32'(alu_calculate_signal_out), 32'd1);
        check("lsb_issue_rs1", alu_rs1val_out, 32'h10);

        // rs2 picks up an ALU broadcast in its own dispatch cycle.
        disp(6'h03, 1'b1, 4'd0, 32'd2, 1'b0, 4'd4, 32'hbeef, 4'd7);
        alu_bc(4'd4, 32'd9); cycle();
        idle(); cycle();
        check("bypass_strobe", 32'(alu_calculate_signal_out), 32'd1);
        check("bypass_rs2", alu_rs2val_out, 32'd9);
        cycle();

        // Fill all entries, drop a ninth dispatch, then free one slot.
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(6'h04, 1'b0, TAG_W'(i + 1), '0, 1'b1, 4'd0, 32'(i), TAG_W'(i));
            cycle();
        end
        check("fill_full", 32'(full_out), 32'd1);
        disp(6'h05, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd15);
        cycle();
        check("drop_full", 32'(full_out), 32'd1);
        idle(); alu_bc(4'd3, 32'h33); cycle();
        idle(); cycle();
        check("wake_strobe", 32'(alu_calculate_signal_out), 32'd1);
        check("wake_dest", 32'(alu_dest_out), 32'd2);
        check("wake_not_full", 32'(full_out), 32'd0);
        rob_clear_in = 1'b1; cycle();
        idle(); cycle();

        // Entries 1 and 5 wake together; the lower index goes first.
        for (int i = 0; i < 6; i++) begin
            disp(6'h06, 1'b0, TAG_W'(10 + i), '0, 1'b1, 4'd0, 32'(i), TAG_W'(i));
            cycle();
        end
        idle(); alu_bc(4'd11, 32'h111); lsb_bc(4'd15, 32'h555); cycle();
        idle(); cycle();
        check("prio_first", 32'(alu_dest_out), 32'd1);
        check("prio_first_val", alu_rs1val_out, 32'h111);
        cycle();
        check("prio_second_strobe", 32'(alu_calculate_signal_out), 32'd1);
        check("prio_second", 32'(alu_dest_out), 32'd5);
        cycle();

        // Flush with a simultaneous dispatch; nothing may issue afterwards.
        disp(6'h07, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 4'd9);
        rob_clear_in = 1'b1; cycle();
        check("clr_strobe", 32'(alu_calculate_signal_out), 32'd0);
        check("clr_full", 32'(full_out), 32'd0);
        idle(); alu_bc(4'd10, 32'h1); lsb_bc(4'd12, 32'h2); cycle();
        idle(); alu_bc(4'd13, 32'h3); lsb_bc(4'd14, 32'h4); cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        check("clr_no_issue", 32'(alu_calculate_signal_out), 32'd0);

        // Same again with an asynchronous reset landing mid-cycle.
        for (int i = 0; i < 4; i++) begin
            disp(6'h08, 1'b0, TAG_W'(i + 1), '0, 1'b1, 4'd0, 32'd0, TAG_W'(i));
            cycle();
        end
        disp(6'h09, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd8, 4'd9);
        cycle();
        idle(); cycle();
        check("pre_rst_strobe", 32'(alu_calculate_signal_out), 32'd1);
        rst_n_in = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_strobe", 32'(alu_calculate_signal_out), 32'd0);
        check("rst_dest", 32'(alu_dest_out), 32'd0);
        #3 rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(); alu_bc(TAG_W'(i + 1), 32'(i)); cycle();
        end
        idle();
        for (int i = 0; i < 2; i++) cycle();
        check("rst_no_issue", 32'(alu_calculate_signal_out), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            rob_clear_in = ($urandom_range(0, 39) == 0);
            dispatch_signal_in = $urandom_range(0, 1) == 1;
            dispatch_op_in = OP_W'($urandom);
            dispatch_imm_in = $urandom; dispatch_pc_in = $urandom;
            dispatch_rs1ready_in = $urandom_range(0, 1) == 1;
            dispatch_rs2ready_in = $urandom_range(0, 1) == 1;
            dispatch_rs1tag_in = TAG_W'($urandom); dispatch_rs2tag_in = TAG_W'($urandom);
            dispatch_rs1val_in = $urandom; dispatch_rs2val_in = $urandom;
            dispatch_dest_in = TAG_W'($urandom);
            alu_broadcast_in = $urandom_range(0, 2) != 0;
            alu_tag_in = TAG_W'($urandom); alu_result_in = $urandom;
            lsb_broadcast_in = $urandom_range(0, 2) != 0;
            lsb_tag_in = ($urandom_range(0, 3) == 0) ? alu_tag_in : TAG_W'($urandom);
            lsb_result_in = $urandom;
            cycle();
        end

        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
